// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings and lane helpers for the memory-access stage
// Purpose: FSM state encoding, access-size encodings, bus widths and the
//          store-lane / misalignment helper functions used by mem_access.
// Ports:   none (package).
package mem_access_pkg;

    localparam int INST_BUS_W     = 32;
    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'd0,
        MEM_ST_REQ  = 2'd1,
        MEM_ST_DONE = 2'd2
    } mem_state_e;

    // Size 2'b11 is handled as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_SIZE_B: is_misaligned = 1'b0;
            MEM_SIZE_H: is_misaligned = off[0];
            default:    is_misaligned = |off;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_SIZE_B: lane_sel = 4'b0001 << off;
            MEM_SIZE_H: lane_sel = off[1] ? 4'b1100 : 4'b0011;
            default:    lane_sel = 4'b1111;
        endcase
    endfunction

    // Replicate the right-justified store data onto every lane so the slave
    // can pick whichever lanes bus_sel enables.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            MEM_SIZE_B: lane_wdata = {4{data[7:0]}};
            MEM_SIZE_H: lane_wdata = {2{data[15:0]}};
            default:    lane_wdata = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - single-outstanding req/ack data bus
// Purpose: bundles the data-bus signals between the memory-access stage
//          (master) and the data memory / interconnect (slave).
// Signals: bus_req, bus_we, bus_addr, bus_sel, bus_wdata (master -> slave)
//          bus_ack, bus_rdata, bus_err (slave -> master, valid with ack)
interface mem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_ack, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_ack, bus_rdata, bus_err
    );
endinterface

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load-data lane extraction and sign/zero extension
// Purpose: combinational; picks the addressed byte/half from a 32-bit bus
//          word and extends it to 32 bits.
// Ports:   rdata (in 32), addr_lo (in 2), size (in 2), unsigned_ld (in 1),
//          data (out 32)
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_SIZE_B: data = {{24{~unsigned_ld & byte_v[7]}}, byte_v};
            MEM_SIZE_H: data = {{16{~unsigned_ld & half_v[15]}}, half_v};
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage (ex_mem -> mem_wb)
// Purpose: runs loads/stores over a single-outstanding req/ack bus, aligns
//          and extends load data, holds the pipeline while a transfer is in
//          flight, and passes the instruction context through to mem_wb.
// Ports:   clk, rst (async, active-low)
//          inst/inst_addr/reg_we/reg_waddr/reg_wdata _i/_o  context in/out
//          mem_req_i, mem_we_i, mem_size_i, mem_unsigned_i, mem_addr_i,
//          mem_wdata_i                                      access request
//          bus (mem_access_if.master)                       data bus
//          hold_req_o, misalign_o, bus_fault_o              status
// Option:  MEM_TIMEOUT_EN - abort a transfer after TIMEOUT_CYCLES REQ cycles
//          without ack (reported as a bus fault).
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INST_BUS_W-1:0]     inst_i,
    output logic [INST_BUS_W-1:0]     inst_o,
    input  logic [31:0]               inst_addr_i,
    output logic [31:0]               inst_addr_o,
    input  logic                      reg_we_i,
    output logic                      reg_we_o,
    input  logic [REG_ADDR_BUS_W-1:0] reg_waddr_i,
    output logic [REG_ADDR_BUS_W-1:0] reg_waddr_o,
    input  logic [REG_BUS_W-1:0]      reg_wdata_i,
    output logic [REG_BUS_W-1:0]      reg_wdata_o,
    input  logic                      mem_req_i,
    input  logic                      mem_we_i,
    input  logic [1:0]                mem_size_i,
    input  logic                      mem_unsigned_i,
    input  logic [31:0]               mem_addr_i,
    input  logic [31:0]               mem_wdata_i,
    mem_access_if.master              bus,
    output logic                      hold_req_o,
    output logic                      misalign_o,
    output logic                      bus_fault_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access: TIMEOUT_CYCLES must be in 1..255");
    end

    mem_state_e  state;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_sel_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] load_q;
    logic        err_q;
    logic [31:0] load_data;
    logic        misaligned;
    logic        start;

`ifdef MEM_TIMEOUT_EN
    logic [7:0]  tmo_cnt;
`endif

    assign misaligned = is_misaligned(mem_size_i, mem_addr_i[1:0]);
    assign start      = (state == MEM_ST_IDLE) && mem_req_i && !misaligned;

    // The ex_mem register is held while hold_req_o is high, so the
    // size/offset/unsigned inputs are still valid when ack arrives.
    mem_load_align u_load_align (
        .rdata       (bus.bus_rdata),
        .addr_lo     (mem_addr_i[1:0]),
        .size        (mem_size_i),
        .unsigned_ld (mem_unsigned_i),
        .data        (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= MEM_ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_sel_q   <= 4'd0;
            bus_wdata_q <= 32'd0;
            load_q      <= 32'd0;
            err_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt     <= 8'd0;
`endif
        end else begin
            case (state)
                MEM_ST_IDLE: begin
                    if (start) begin
                        state       <= MEM_ST_REQ;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_we_i;
                        bus_addr_q  <= {mem_addr_i[31:2], 2'b00};
                        bus_sel_q   <= lane_sel(mem_size_i, mem_addr_i[1:0]);
                        bus_wdata_q <= lane_wdata(mem_size_i, mem_wdata_i);
                        err_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt     <= 8'd0;
`endif
                    end
                end
                MEM_ST_REQ: begin
                    // Ack is checked first so a same-cycle ack beats the timeout.
                    if (bus.bus_ack) begin
                        state     <= MEM_ST_DONE;
                        bus_req_q <= 1'b0;
                        load_q    <= load_data;
                        err_q     <= bus.bus_err;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_cnt + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
                        state     <= MEM_ST_DONE;
                        bus_req_q <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        tmo_cnt   <= tmo_cnt + 8'd1;
                    end
`endif
                end
                MEM_ST_DONE: state <= MEM_ST_IDLE;
                default:     state <= MEM_ST_IDLE;
            endcase
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_sel   = bus_sel_q;
    assign bus.bus_wdata = bus_wdata_q;

    // rst gates hold so the pipeline is released as soon as reset asserts,
    // even though a memory instruction may still sit in ex_mem.
    assign hold_req_o  = rst & (start | (state == MEM_ST_REQ));
    assign bus_fault_o = (state == MEM_ST_DONE) & err_q;

    always_comb begin
        inst_o      = inst_i;
        inst_addr_o = inst_addr_i;
        reg_waddr_o = reg_waddr_i;
        reg_wdata_o = reg_wdata_i;
        reg_we_o    = reg_we_i;
        misalign_o  = 1'b0;
        case (state)
            MEM_ST_IDLE: begin
                // Suppress the write both while stalling and for a trapped
                // misaligned access.
                if (mem_req_i) begin
                    reg_we_o   = 1'b0;
                    misalign_o = misaligned;
                end
            end
            MEM_ST_REQ: reg_we_o = 1'b0;
            MEM_ST_DONE: begin
                reg_we_o = reg_we_i & ~err_q;
                if (!mem_we_i) begin
                    reg_wdata_o = load_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for the memory-access stage
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, inst_o, inst_addr_i, inst_addr_o;
    logic        reg_we_i, reg_we_o;
    logic [4:0]  reg_waddr_i, reg_waddr_o;
    logic [31:0] reg_wdata_i, reg_wdata_o;
    logic        mem_req_i, mem_we_i, mem_unsigned_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic        hold_req_o, misalign_o, bus_fault_o;

    logic [31:0] ra_rdata, ra_data;
    logic [1:0]  ra_off, ra_size;
    logic        ra_uns;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] wdata;
        logic        we;
        logic        fault;
        logic        chk_wdata;
    } exp_t;
    exp_t sb[$];

    mem_access_if bus_if ();

    always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
    mem_access #(.TIMEOUT_CYCLES(4)) dut (
`else
    mem_access dut (
`endif
        .clk            (clk),
        .rst            (rst),
        .inst_i         (inst_i),
        .inst_o         (inst_o),
        .inst_addr_i    (inst_addr_i),
        .inst_addr_o    (inst_addr_o),
        .reg_we_i       (reg_we_i),
        .reg_we_o       (reg_we_o),
        .reg_waddr_i    (reg_waddr_i),
        .reg_waddr_o    (reg_waddr_o),
        .reg_wdata_i    (reg_wdata_i),
        .reg_wdata_o    (reg_wdata_o),
        .mem_req_i      (mem_req_i),
        .mem_we_i       (mem_we_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .bus            (bus_if),
        .hold_req_o     (hold_req_o),
        .misalign_o     (misalign_o),
        .bus_fault_o    (bus_fault_o)
    );

    mem_load_align ref_align (
        .rdata       (ra_rdata),
        .addr_lo     (ra_off),
        .size        (ra_size),
        .unsigned_ld (ra_uns),
        .data        (ra_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] v;
        case (size)
            2'b00: begin
                v = (rdata >> (int'(off) * 8)) & 32'h0000_00FF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (rdata >> (int'(off[1]) * 16)) & 32'h0000_FFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_bwdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    task automatic idle_inputs();
        mem_req_i      = 1'b0;
        mem_we_i       = 1'b0;
        mem_size_i     = 2'b10;
        mem_unsigned_i = 1'b0;
        mem_addr_i     = 32'd0;
        mem_wdata_i    = 32'd0;
        reg_we_i       = 1'b0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_err   = 1'b0;
        bus_if.bus_rdata = 32'd0;
    endtask

    // Entered and left on a falling edge. ack_at = REQ cycle carrying ack
    // (0 = never); exp_req = REQ cycles expected before DONE.
    task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] data,
                             input logic rwe, input logic [31:0] rdata, input logic err,
                             input int ack_at, input int exp_req);
        exp_t e;
        exp_t got_e;
        int   req_cycles = 0;
        int   hold_cycles = 0;
        bit   done = 1'b0;

        mem_req_i      = 1'b1;
        mem_we_i       = we;
        mem_size_i     = size;
        mem_unsigned_i = uns;
        mem_addr_i     = addr;
        mem_wdata_i    = data;
        reg_we_i       = rwe;
        reg_waddr_i    = 5'($urandom_range(1, 31));
        reg_wdata_i    = $urandom;
        inst_i         = $urandom;
        inst_addr_i    = $urandom & 32'hFFFF_FFFC;

        e.wdata     = we ? reg_wdata_i : ref_load(rdata, addr[1:0], size, uns);
        e.we        = rwe & ~err;
        e.fault     = err;
        e.chk_wdata = !err;
        sb.push_back(e);

        #1;
        check({tag, "/idle_hold"}, 32'(hold_req_o), 32'd1);
        check({tag, "/idle_we"}, 32'(reg_we_o), 32'd0);
        if (hold_req_o) hold_cycles++;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 64 && !done; i++) begin
            if (bus_if.bus_req) begin
                req_cycles++;
                if (hold_req_o) hold_cycles++;
                check({tag, "/req_we_o"}, 32'(reg_we_o), 32'd0);
                if (req_cycles == 1) begin
                    check({tag, "/bus_we"}, 32'(bus_if.bus_we), 32'(we));
                    check({tag, "/bus_addr"}, bus_if.bus_addr, {addr[31:2], 2'b00});
                    check({tag, "/bus_sel"}, 32'(bus_if.bus_sel), 32'(ref_sel(size, addr[1:0])));
                    if (we) check({tag, "/bus_wdata"}, bus_if.bus_wdata, ref_bwdata(size, data));
                end
                if (req_cycles == ack_at) begin
                    bus_if.bus_ack   = 1'b1;
                    bus_if.bus_rdata = rdata;
                    bus_if.bus_err   = err;
                end
                @(posedge clk);
                @(negedge clk);
                bus_if.bus_ack   = 1'b0;
                bus_if.bus_err   = 1'b0;
                bus_if.bus_rdata = $urandom;
            end else begin
                done = 1'b1;
            end
        end
        check({tag, "/req_cycles"}, 32'(req_cycles), 32'(exp_req));
        check({tag, "/hold_cycles"}, 32'(hold_cycles), 32'(exp_req + 1));

        #1;
        check({tag, "/done_hold"}, 32'(hold_req_o), 32'd0);
        got_e = sb.pop_front();
        check({tag, "/done_we"}, 32'(reg_we_o), 32'(got_e.we));
        check({tag, "/done_fault"}, 32'(bus_fault_o), 32'(got_e.fault));
        if (got_e.chk_wdata) check({tag, "/done_wdata"}, reg_wdata_o, got_e.wdata);
        check({tag, "/inst"}, inst_o, inst_i);
        check({tag, "/waddr"}, 32'(reg_waddr_o), 32'(reg_waddr_i));

        @(posedge clk);
        @(negedge clk);
        mem_req_i = 1'b0;
        reg_we_i  = 1'b0;
        #1;
        check({tag, "/post_fault"}, 32'(bus_fault_o), 32'd0);
        check({tag, "/post_hold"}, 32'(hold_req_o), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [1:0]  off;
        logic [31:0] a;

        rst = 1'b0;
        idle_inputs();
        inst_i = 32'h0000_0013;
        inst_addr_i = 32'h0;
        reg_waddr_i = 5'd0;
        reg_wdata_i = 32'd0;

        // Reference alignment model against the bench's own extraction.
        ra_rdata = 32'h80F1_7F82;
        for (int s = 0; s < 3; s++) begin
            for (int o = 0; o < 4; o++) begin
                for (int u = 0; u < 2; u++) begin
                    ra_size = 2'(s);
                    ra_off  = 2'(o);
                    ra_uns  = u[0];
                    #1;
                    check("align_model", ra_data, ref_load(ra_rdata, ra_off, ra_size, ra_uns));
                end
            end
        end

        // Reset state, with an aligned request already presented.
        @(negedge clk);
        mem_req_i = 1'b1;
        #1;
        check("rst/bus_req", 32'(bus_if.bus_req), 32'd0);
        check("rst/hold", 32'(hold_req_o), 32'd0);
        check("rst/fault", 32'(bus_fault_o), 32'd0);
        mem_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Non-memory passthrough.
        reg_we_i    = 1'b1;
        reg_wdata_i = 32'h1234_5678;
        reg_waddr_i = 5'd7;
        inst_i      = 32'h00A5_0533;
        #1;
        check("pass/wdata", reg_wdata_o, 32'h1234_5678);
        check("pass/we", 32'(reg_we_o), 32'd1);
        check("pass/waddr", 32'(reg_waddr_o), 32'd7);
        check("pass/inst", inst_o, 32'h00A5_0533);
        check("pass/hold", 32'(hold_req_o), 32'd0);
        reg_we_i = 1'b0;
        @(negedge clk);

        do_access("lw_wait", 1'b0, 2'b10, 1'b0, 32'h1000, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3, 3);
        do_access("lb", 1'b0, 2'b00, 1'b0, 32'h1003, 32'd0, 1'b1, 32'h8012_3456, 1'b0, 1, 1);
        do_access("lbu", 1'b0, 2'b00, 1'b1, 32'h1003, 32'd0, 1'b1, 32'h8012_3456, 1'b0, 1, 1);
        do_access("sh", 1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_ABCD, 1'b0, 32'd0, 1'b0, 1, 1);
        do_access("sb", 1'b1, 2'b00, 1'b0, 32'h2001, 32'h0000_00C3, 1'b0, 32'd0, 1'b0, 2, 2);
        do_access("lw_err", 1'b0, 2'b10, 1'b0, 32'h3000, 32'd0, 1'b1, 32'h1111_2222, 1'b1, 1, 1);

        // Misaligned word and half: trapped without bus access.
        for (int k = 0; k < 2; k++) begin
            mem_req_i  = 1'b1;
            mem_we_i   = 1'b0;
            mem_size_i = (k == 0) ? 2'b10 : 2'b01;
            mem_addr_i = (k == 0) ? 32'h1001 : 32'h2003;
            reg_we_i   = 1'b1;
            for (int c = 0; c < 3; c++) begin
                #1;
                check("mis/misalign", 32'(misalign_o), 32'd1);
                check("mis/bus_req", 32'(bus_if.bus_req), 32'd0);
                check("mis/hold", 32'(hold_req_o), 32'd0);
                check("mis/we", 32'(reg_we_o), 32'd0);
                @(negedge clk);
            end
        end
        idle_inputs();
        @(negedge clk);

        // Reset mid-REQ.
        mem_req_i  = 1'b1;
        mem_size_i = 2'b10;
        mem_addr_i = 32'h4000;
        @(posedge clk);
        @(negedge clk);
        check("rreq/in_req", 32'(bus_if.bus_req), 32'd1);
        rst = 1'b0;
        #1;
        check("rreq/bus_req", 32'(bus_if.bus_req), 32'd0);
        check("rreq/hold", 32'(hold_req_o), 32'd0);
        check("rreq/fault", 32'(bus_fault_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_req_i = 1'b0;
        @(negedge clk);
        check("rreq/idle_req", 32'(bus_if.bus_req), 32'd0);
        check("rreq/idle_hold", 32'(hold_req_o), 32'd0);

        // Randomised aligned loads and stores.
        for (int n = 0; n < 8; n++) begin
            sz  = 2'($urandom_range(0, 3));
            off = 2'($urandom_range(0, 3));
            if (sz == 2'b01) off[0] = 1'b0;
            if (sz[1]) off = 2'b00;
            a = ($urandom & 32'hFFFF_FFFC) | 32'(off);
            if (n[0])
                do_access("rnd_st", 1'b1, sz, 1'b0, a, $urandom, 1'b0, 32'd0, 1'b0,
                          n % 3 + 1, n % 3 + 1);
            else
                do_access("rnd_ld", 1'b0, sz, 1'($urandom_range(0, 1)), a, 32'd0, 1'b1,
                          $urandom, 1'b0, n % 3 + 1, n % 3 + 1);
        end

`ifdef MEM_TIMEOUT_EN
        do_access("timeout", 1'b0, 2'b10, 1'b0, 32'h5000, 32'd0, 1'b1, 32'd0, 1'b1, 0, 4);
        do_access("tmo_tie", 1'b0, 2'b10, 1'b0, 32'h5004, 32'd0, 1'b1, 32'hCAFE_F00D, 1'b0, 4, 4);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
